// File: rtl/addsub_serial.sv
// -----------------------------------------------------------------------------
// addsub_serial
// Digit-serial two's-complement adder/subtractor. Each operation consumes
// WIDTH/DIGIT cycles, adding DIGIT bits per cycle through a narrow carry chain.
// It reports signed overflow and can optionally saturate the result.
//
// Parameters
//   WIDTH     operand/result width (multiple of DIGIT, >= 2)
//   DIGIT     bits processed per cycle (1..WIDTH)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request, accepted while ready=1
//   op        0 = a+b, 1 = a-b          (sampled with start)
//   sat       saturate on overflow      (sampled with start)
//   a, b      operands                  (sampled with start)
//   ready     idle or completing; start accepted
//   valid     one-cycle pulse, result/flags updated
//   result    sum/difference (saturated when requested)
//   carry_out raw carry out of MSB (subtract: 1 = no borrow)
//   overflow  signed overflow of the unsaturated result
//   zero      result == 0
// -----------------------------------------------------------------------------
module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic             sat,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Saturation bound: most negative value for a negative A, else most positive.
    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        logic [WIDTH-1:0] min_v;
        min_v = {1'b1, {(WIDTH-1){1'b0}}};
        return neg ? min_v : ~min_v;
    endfunction

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             sat_r;
    logic             a_sign_r;

    logic [WIDTH-1:0] result_r;
    logic             carry_out_r;
    logic             overflow_r;
    logic             zero_r;
    logic             valid_r;

    logic                   accept_s;
    logic                   last_s;
    logic [DIGIT-1:0]       a_dig_s;
    logic [DIGIT-1:0]       b_dig_s;
    logic [DIGIT:0]         dsum_s;
    logic [WIDTH+DIGIT-1:0] cat_s;
    logic [WIDTH-1:0]       acc_next_s;
    logic                   ovf_s;
    logic [WIDTH-1:0]       final_s;
    logic [1:0]             state_next_s;

    assign ready    = (state_r != S_RUN);
    assign accept_s = start && ready;
    assign last_s   = (cnt_r == CW'(N - 1));

    // Operands shift right each cycle, so the active digit is always the low DIGIT bits.
    assign a_dig_s = a_r[DIGIT-1:0];
    assign b_dig_s = b_r[DIGIT-1:0];
    assign dsum_s  = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};

    // New sum digit enters at the top; after N digits the word is aligned.
    assign cat_s      = {dsum_s[DIGIT-1:0], acc_r};
    assign acc_next_s = cat_s[WIDTH+DIGIT-1:DIGIT];

    // Equivalent to (carry into MSB) XOR (carry out of MSB) on the final digit.
    assign ovf_s = (a_dig_s[DIGIT-1] == b_dig_s[DIGIT-1]) &&
                   (dsum_s[DIGIT-1] != a_dig_s[DIGIT-1]);

    // Final result selection, applied only on the last digit.
    always_comb begin
        final_s = acc_next_s;
        if (sat_r && ovf_s) begin
            final_s = sat_value(a_sign_r);
        end else begin
            final_s = acc_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_next_s = S_RUN;
                else          state_next_s = S_IDLE;
            end
            S_RUN: begin
                if (last_s) state_next_s = S_DONE;
                else        state_next_s = S_RUN;
            end
            S_DONE: begin
                if (accept_s) state_next_s = S_RUN;
                else          state_next_s = S_IDLE;
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // State register and serial datapath (operand load, digit shift, carry).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            carry_r  <= 1'b0;
            sat_r    <= 1'b0;
            a_sign_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                // Subtract is a + ~b + 1: the +1 rides in as the initial carry.
                a_r      <= a;
                b_r      <= b ^ {WIDTH{op}};
                carry_r  <= op;
                sat_r    <= sat;
                a_sign_r <= a[WIDTH-1];
                cnt_r    <= {CW{1'b0}};
            end else if (state_r == S_RUN) begin
                a_r     <= a_r >> DIGIT;
                b_r     <= b_r >> DIGIT;
                acc_r   <= acc_next_s;
                carry_r <= dsum_s[DIGIT];
                cnt_r   <= cnt_r + CW'(1);
            end else begin
                a_r <= a_r;
            end
        end
    end

    // Result/flag registers, updated only as the last digit completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_r    <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            overflow_r  <= 1'b0;
            zero_r      <= 1'b0;
            valid_r     <= 1'b0;
        end else if (state_r == S_RUN && last_s) begin
            result_r    <= final_s;
            carry_out_r <= dsum_s[DIGIT];
            overflow_r  <= ovf_s;
            zero_r      <= (final_s == {WIDTH{1'b0}});
            valid_r     <= 1'b1;
        end else begin
            valid_r     <= 1'b0;
        end
    end

    assign valid     = valid_r;
    assign result    = result_r;
    assign carry_out = carry_out_r;
    assign overflow  = overflow_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_addsub_serial
// Directed bench for addsub_serial. A WIDTH=8/DIGIT=4 instance carries the
// directed scenarios; three more instances (8/1, 8/8, 16/4) share one stimulus
// port and are compared against an integer reference model. Latency is counted
// in cycles with the cycle that presents start counted as cycle 1.
// -----------------------------------------------------------------------------
module tb_addsub_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main 8/4 instance
    logic       start, op, sat;
    logic [7:0] a, b;
    logic       ready, valid, carry_out, overflow, zero;
    logic [7:0] result;

    addsub_serial #(.WIDTH(8), .DIGIT(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sat(sat),
        .a(a), .b(b), .ready(ready), .valid(valid), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    // Sweep instances sharing one request port
    logic        s_start, s_op, s_sat;
    logic [15:0] s_a, s_b;
    logic        r1, v1, c1, o1, z1;  logic [7:0]  res1;
    logic        r8, v8, c8, o8, z8;  logic [7:0]  res8;
    logic        rw, vw, cw, ow, zw;  logic [15:0] resw;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .sat(s_sat),
        .a(s_a[7:0]), .b(s_b[7:0]), .ready(r1), .valid(v1), .result(res1),
        .carry_out(c1), .overflow(o1), .zero(z1)
    );
    addsub_serial #(.WIDTH(8), .DIGIT(8)) u_w8d8 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .sat(s_sat),
        .a(s_a[7:0]), .b(s_b[7:0]), .ready(r8), .valid(v8), .result(res8),
        .carry_out(c8), .overflow(o8), .zero(z8)
    );
    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .op(s_op), .sat(s_sat),
        .a(s_a), .b(s_b), .ready(rw), .valid(vw), .result(resw),
        .carry_out(cw), .overflow(ow), .zero(zw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the operands.
    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic iop, input logic isat);
        a = ia; b = ib; op = iop; sat = isat; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ia; b = ~ib; op = ~iop; sat = ~isat;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (valid !== 1'b1) begin
            checks++; errors++;
            $error("FAIL valid_timeout: observed no valid expected valid");
        end
    endtask

    task automatic run_main(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                            input logic iop, input logic isat,
                            input logic [7:0] er, input logic ec, input logic eo, input logic ez);
        int lat;
        start_op(ia, ib, iop, isat);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 3);
        check({tag, "_res"}, {24'd0, result}, {24'd0, er});
        check({tag, "_cout"}, {31'd0, carry_out}, {31'd0, ec});
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    // Integer reference: returns {zero, ovf, cout, result[15:0]}
    function automatic logic [18:0] ref_model(input int w, input logic [15:0] ia, input logic [15:0] ib,
                                              input logic iop, input logic isat);
        longint ua, ub, sa, sb, r, mx, mn, full, res;
        logic ovf, cout;
        full = longint'(1) << w;
        ua = longint'(ia) & (full - 1);
        ub = longint'(ib) & (full - 1);
        sa = (ua >= (full >> 1)) ? ua - full : ua;
        sb = (ub >= (full >> 1)) ? ub - full : ub;
        mx = (full >> 1) - 1;
        mn = -(full >> 1);
        r = iop ? sa - sb : sa + sb;
        ovf = (r > mx) || (r < mn);
        cout = iop ? (ua >= ub) : ((ua + ub) >= full);
        res = (ovf && isat) ? ((sa < 0) ? mn : mx) : r;
        res = res & (full - 1);
        return {(res == 0), ovf, cout, res[15:0]};
    endfunction

    initial begin
        int lat, cnt;
        int lat1, lat8, latw;
        logic [18:0] e1, e8, ew;
        logic [18:0] g1, g8, gw;

        start = 1'b0; op = 1'b0; sat = 1'b0; a = 8'd0; b = 8'd0;
        s_start = 1'b0; s_op = 1'b0; s_sat = 1'b0; s_a = 16'd0; s_b = 16'd0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_cout", {31'd0, carry_out}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed arithmetic cases
        run_main("add127",   8'd100, 8'd27, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0);
        run_main("posovf",   8'd100, 8'd28, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_main("possat",   8'd100, 8'd28, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_main("negsat",   8'h80,  8'd1,  1'b1, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0);
        run_main("subzero",  8'd5,   8'd5,  1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_main("subneg",   8'd3,   8'd7,  1'b1, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0);

        // Back-to-back: start in the DONE cycle
        start_op(8'd3, 8'd4, 1'b0, 1'b0);
        wait_valid(lat);
        check("b2b_first", {24'd0, result}, 32'd7);
        check("b2b_ready_done", {31'd0, ready}, 32'd1);
        start_op(8'd10, 8'd20, 1'b0, 1'b0);
        check("b2b_valid_width", {31'd0, valid}, 32'd0);
        check("b2b_ready_run", {31'd0, ready}, 32'd0);
        check("b2b_hold", {24'd0, result}, 32'd7);
        // Pulse start during RUN with other operands: must be ignored
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("run_start_novalid", {31'd0, valid}, 32'd0);
        lat = 2;
        while (valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_lat", lat, 3);
        check("b2b_second", {24'd0, result}, 32'd30);
        cnt = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid === 1'b1) cnt++;
        end
        check("no_extra_valid", cnt, 0);
        check("ignored_hold", {24'd0, result}, 32'd30);

        // Reset in the middle of an operation
        start_op(8'd50, 8'd60, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        check("midrst_result", {24'd0, result}, 32'd0);
        check("midrst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (valid === 1'b1) cnt++;
        end
        check("midrst_novalid", cnt, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_main("postrst", 8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);

        // Width/digit sweep against the reference model
        for (int k = 0; k < 12; k++) begin
            if (k == 0) begin
                s_a = 16'h8000; s_b = 16'h0001; s_op = 1'b1; s_sat = 1'b1;
            end else if (k == 1) begin
                s_a = 16'h7F7F; s_b = 16'h0101; s_op = 1'b0; s_sat = 1'b0;
            end else begin
                s_a = 16'($urandom); s_b = 16'($urandom);
                s_op = 1'($urandom); s_sat = 1'($urandom);
            end
            e1 = ref_model(8, s_a, s_b, s_op, s_sat);
            e8 = ref_model(8, s_a, s_b, s_op, s_sat);
            ew = ref_model(16, s_a, s_b, s_op, s_sat);
            s_start = 1'b1;
            @(posedge clk); #1;
            s_start = 1'b0; s_a = ~s_a; s_b = ~s_b;
            lat1 = 0; lat8 = 0; latw = 0;
            g1 = '0; g8 = '0; gw = '0;
            for (int c = 2; c <= 14; c++) begin
                @(posedge clk); #1;
                if (v1 === 1'b1) begin lat1 = c; g1 = {z1, o1, c1, 8'd0, res1}; end
                if (v8 === 1'b1) begin lat8 = c; g8 = {z8, o8, c8, 8'd0, res8}; end
                if (vw === 1'b1) begin latw = c; gw = {zw, ow, cw, resw}; end
            end
            e1[15:8] = 8'd0;
            e8[15:8] = 8'd0;
            check($sformatf("sw%0d_8d1_lat", k), lat1, 9);
            check($sformatf("sw%0d_8d1_out", k), {13'd0, g1}, {13'd0, e1});
            check($sformatf("sw%0d_8d8_lat", k), lat8, 2);
            check($sformatf("sw%0d_8d8_out", k), {13'd0, g8}, {13'd0, e8});
            check($sformatf("sw%0d_16d4_lat", k), latw, 5);
            check($sformatf("sw%0d_16d4_out", k), {13'd0, gw}, {13'd0, ew});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised, digit-serial two's-complement adder/subtractor with overflow detection and optional saturation. It processes `DIGIT` bits per clock over `WIDTH/DIGIT` cycles, trading latency for a narrow carry chain. It sits beside the combinational 8-bit adder/subtractor in the arithmetic library. Requests use a start/ready/valid handshake, so a controller or datapath sequencer can issue operations back to back.

## Interface
- `WIDTH`, default 16: operand and result width; must be an integer multiple of `DIGIT`, minimum 2.
- `DIGIT`, default 4: bits processed per cycle, range 1..`WIDTH`. Define `N = WIDTH/DIGIT`.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only while `ready`=1.
- `op`  in  1  0 = a+b, 1 = a−b; sampled with `start`.
- `sat`  in  1  1 = saturate on signed overflow; sampled with `start`.
- `a`  in  `WIDTH`  operand A, two's complement; sampled with `start`.
- `b`  in  `WIDTH`  operand B, two's complement; sampled with `start`.
- `ready`  out  1  block idle or completing; `start` accepted.
- `valid`  out  1  one-cycle pulse: result and flags are new.
- `result`  out  `WIDTH`  sum/difference (saturated when `sat` and overflow).
- `carry_out`  out  1  raw carry out of the MSB (for subtract: 1 = no borrow).
- `overflow`  out  1  signed overflow of the unsaturated result.
- `zero`  out  1  `result` (post-saturation) == 0.

## Operation
- States: IDLE, RUN, DONE. During reset: IDLE; `ready`=1, `valid`=0, `result`=0, `carry_out`=0, `overflow`=0, `zero`=0.
- Accept (`start` && `ready`):
  - latch `a`, `b XOR {WIDTH{op}}`, `op`, `sat`;
  - carry register := `op`; digit counter := 0; go to RUN.
- RUN, each cycle:
  - add digit `cnt` of A and B' with the carry register;
  - write the `DIGIT` sum bits into the result shift/accumulate register;
  - carry register := digit carry-out; `cnt`++.
- On the last digit (`cnt`=N−1):
  - capture the carry into the MSB (`c_msb`) and the carry out of the MSB;
  - go to DONE.
- DONE, one cycle:
  - `overflow` = `c_msb` XOR carry-out;
  - if `sat` && `overflow`: `result` = 0x7F..F when latched `a[WIDTH-1]`=0, else 0x80..0;
  - `zero` computed on the final `result`; `valid`=1.
  - Next state: RUN if `start` is accepted this cycle, else IDLE.
- `ready` = 1 in IDLE and DONE, 0 in RUN. `start` in RUN is ignored (not queued).
- Outputs `result`/`carry_out`/`overflow`/`zero` hold their last values until the next DONE. They are not cleared by a new `start`.
- Input changes after acceptance have no effect on the operation in flight.
- `DIGIT`=`WIDTH` (N=1): a single RUN cycle; handshake timing is otherwise unchanged.
- `rst_n` asserted mid-operation: immediate return to IDLE with reset values; the partial result is discarded and no `valid` is issued.

## Timing
- `start` sampled at edge T0.
- RUN occupies edges T1..TN.
- DONE (`valid`=1, `ready`=1) is the cycle after edge TN: from edge TN to edge TN+1.
- Latency: `valid` is high N+1 cycles after the accepting edge. Throughput: one op per N+1 cycles with back-to-back `start` in DONE.
- All outputs are registered; there is no combinational path from inputs to outputs, except `ready`, which is decoded from state only.
- `valid` is exactly one cycle wide.

## Test plan
Settings: WIDTH=8, DIGIT=4, N=2.
- Add without overflow: a=100, b=27, op=0, sat=0 → `valid` 3 cycles after start, `result`=0x7F, `overflow`=0, `carry_out`=0, `zero`=0.
- Positive overflow: a=100, b=28, op=0 → with sat=0, `result`=0x80, `overflow`=1; with sat=1, `result`=0x7F, `overflow`=1.
- Subtract overflow and zero:
  - a=0x80, b=1, op=1, sat=1 → `result`=0x80 (saturated), `overflow`=1;
  - a=5, b=5, op=1 → `result`=0, `zero`=1, `carry_out`=1.
- Handshake: assert `start` in the DONE cycle → second op accepted, its `valid` 3 cycles later. Pulse `start` during RUN with different operands → ignored; the first result is unchanged and no extra `valid` is issued.
- Reset mid-op: start a=50, b=60, then drop `rst_n` after edge T1 → all outputs at reset values, `ready`=1. After release, a new start a=1, b=2 yields `result`=3.
- Sweep WIDTH/DIGIT ∈ {8/1, 8/8, 16/4}: random operands against a reference model → `result`/flags match and latency equals N+1 in every case.
